// File: rtl/mag_pkg.sv
// Shared types and constants for the round-robin magnitude scheduler.
// Provides the round-robin winner search used by the arbiter.
package mag_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SQUARE = 2'd1,
    ROOT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int OPW   = 8;
  localparam int SUMW  = 17;
  localparam int ROOTW = 9;

  // First set bit of valid at or after ptr+1, wrapping modulo n; ptr if none set.
  function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                         input logic [2:0] ptr,
                                         input int         n);
    logic [2:0] pick;
    int         idx;
    pick = ptr;
    for (int k = n; k >= 1; k--) begin
      idx = (int'(ptr) + k) % n;
      if (valid[3'(idx)]) pick = 3'(idx);
    end
    return pick;
  endfunction

endpackage

// File: rtl/mag_sched_if.sv
// Request/response bundle between the requesters and the magnitude scheduler.
interface mag_sched_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  import mag_pkg::*;

  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [OPW*N-1:0] req_x;
  logic [OPW*N-1:0] req_y;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [ROOTW-1:0] rsp_mag;
  logic [IDW-1:0]   rsp_id;

  modport master (
    output req_valid, req_x, req_y, rsp_ready,
    input  req_ready, rsp_valid, rsp_mag, rsp_id
  );

  modport slave (
    input  req_valid, req_x, req_y, rsp_ready,
    output req_ready, rsp_valid, rsp_mag, rsp_id
  );

endinterface

// File: rtl/mag_isqrt_core.sv
// Bit-serial restoring integer square root: latches a 17-bit radicand on start,
// resolves one root bit per cycle MSB first, and pulses done with the 9-bit root.
module mag_isqrt_core
  import mag_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SUMW-1:0]  radicand,
  output logic             done,
  output logic [ROOTW-1:0] root
);

  localparam int RADW = 2 * ROOTW;
  localparam int REMW = ROOTW + 1;

  logic             run;
  logic [3:0]       cnt;
  logic [RADW-1:0]  rad;
  logic [REMW-1:0]  rem;
  logic [ROOTW-1:0] root_q;
  logic [REMW+1:0]  rem_sh;
  logic [REMW+1:0]  trial;
  logic             fits;
  logic [REMW-1:0]  rem_nx;

  // Remainder never exceeds 2*root, so REMW bits hold it between steps.
  assign rem_sh = {rem, rad[RADW-1 -: 2]};
  assign trial  = {1'b0, root_q, 2'b01};
  assign fits   = (rem_sh >= trial);
  assign rem_nx = fits ? REMW'(rem_sh - trial) : rem_sh[REMW-1:0];
  assign root   = root_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run  <= 1'b0;
      cnt  <= '0;
      done <= 1'b0;
    end else begin
      done <= run && (cnt == 4'd0);
      if (start) begin
        run <= 1'b1;
        cnt <= 4'(ROOTW - 1);
      end else if (run) begin
        if (cnt == 4'd0) run <= 1'b0;
        else             cnt <= cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      rad    <= RADW'(radicand);
      rem    <= '0;
      root_q <= '0;
    end else if (run) begin
      rad    <= {rad[RADW-3:0], 2'b00};
      rem    <= rem_nx;
      root_q <= {root_q[ROOTW-2:0], fits};
    end
  end

endmodule

// File: rtl/mag_sched.sv
// Round-robin front end sharing one iterative magnitude engine among N requesters:
// arbitration, operand capture, sequencing and the response handshake.
module mag_sched
  import mag_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  mag_sched_if.slave bus,
  output logic       busy
);

  state_t           state;
  state_t           state_nx;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   id_cap;
  logic [OPW-1:0]   x_sel;
  logic [OPW-1:0]   y_sel;
  logic [OPW-1:0]   x_cap;
  logic [OPW-1:0]   y_cap;
  logic [SUMW-1:0]  sum;
  logic             any_valid;
  logic             accept;
  logic             core_start;
  logic             core_done;
  logic [ROOTW-1:0] core_root;
  logic [ROOTW-1:0] mag_q;
  logic [IDW-1:0]   rsp_id_q;

  assign any_valid = |bus.req_valid;
  assign win       = IDW'(rr_pick(8'(bus.req_valid), 3'(ptr), N));
  assign accept    = |(bus.req_valid & bus.req_ready);

  // Grant is only offered in IDLE and never while reset is held.
  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && rst_n && any_valid) bus.req_ready[win] = 1'b1;
  end

  always_comb begin
    x_sel = '0;
    y_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (IDW'(i) == win) begin
        x_sel = bus.req_x[i*OPW +: OPW];
        y_sel = bus.req_y[i*OPW +: OPW];
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SQUARE;
      SQUARE:  state_nx = ROOT;
      ROOT:    if (core_done) state_nx = DONE;
      DONE:    if (bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= IDW'(N - 1);
      mag_q    <= '0;
      rsp_id_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) ptr <= win;
      if (state == ROOT && core_done) begin
        mag_q    <= core_root;
        rsp_id_q <= id_cap;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      x_cap  <= x_sel;
      y_cap  <= y_sel;
      id_cap <= win;
    end
  end

  // SQUARE cycle: full-width sum of squares handed to the root engine.
  assign sum        = SUMW'(x_cap) * SUMW'(x_cap) + SUMW'(y_cap) * SUMW'(y_cap);
  assign core_start = (state == SQUARE);

  mag_isqrt_core u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (core_start),
    .radicand (sum),
    .done     (core_done),
    .root     (core_root)
  );

  assign bus.rsp_valid = (state == DONE);
  assign bus.rsp_mag   = mag_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_mag_sched.sv
// Randomized bench for mag_sched against an arithmetic model of grants and magnitudes.
module tb_mag_sched;
  localparam int N   = 4;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;
  int   checks = 0;
  int   errors = 0;
  int   model_ptr = N - 1;
  int   gid;

  mag_sched_if #(.N(N), .IDW(IDW)) bus ();

  mag_sched #(.N(N), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_mag(input int x, input int y);
    int s;
    int r;
    s = x * x + y * y;
    r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  function automatic int ref_pick(input logic [N-1:0] mask);
    int order[$];
    for (int k = 1; k <= N; k++) order.push_back((model_ptr + k) % N);
    foreach (order[j]) if (mask[order[j]]) return order[j];
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic set_op(input int i, input int x, input int y);
    bus.req_x[8*i +: 8] = 8'(x);
    bus.req_y[8*i +: 8] = 8'(y);
  endtask

  task automatic xact(input logic [N-1:0] mask, input int hold, input bit scramble, output int got);
    int n, exp_id, exp_mag, lat, bad;
    logic [8:0]     mag_seen;
    logic [IDW-1:0] id_seen;
    got = -1;
    bus.rsp_ready = (hold == 0);
    bus.req_valid = mask;
    #1;
    n = 0;
    while (bus.req_ready == '0 && n < 40) begin
      tick();
      n++;
    end
    chk("grant_seen", int'(bus.req_ready != '0), 1);
    exp_id = ref_pick(mask);
    chk("grant_onehot", $countones(bus.req_ready), 1);
    got = onehot_idx(bus.req_ready);
    chk("grant_id", got, exp_id);
    if (got < 0) return;
    exp_mag = ref_mag(int'(bus.req_x[8*got +: 8]), int'(bus.req_y[8*got +: 8]));
    tick();
    model_ptr = got;
    bus.req_valid[got] = 1'b0;
    if (scramble) for (int i = 0; i < N; i++) set_op(i, $urandom_range(255), $urandom_range(255));
    lat = 0;
    bad = 0;
    while (!bus.rsp_valid && lat < 30) begin
      if (!busy || bus.req_ready != '0) bad++;
      tick();
      lat++;
    end
    chk("latency", lat, 11);
    chk("busy_no_grant", bad, 0);
    chk("rsp_mag", int'(bus.rsp_mag), exp_mag);
    chk("rsp_id", int'(bus.rsp_id), exp_id);
    chk("done_no_grant", int'(bus.req_ready), 0);
    mag_seen = bus.rsp_mag;
    id_seen  = bus.rsp_id;
    bad = 0;
    for (int h = 0; h < hold; h++) begin
      tick();
      if (!bus.rsp_valid || bus.rsp_mag != mag_seen || bus.rsp_id != id_seen || bus.req_ready != '0) bad++;
    end
    if (hold > 0) chk("hold_stable", bad, 0);
    bus.rsp_ready = 1'b1;
    tick();
    chk("rsp_released", int'(bus.rsp_valid), 0);
    chk("mag_kept", int'(bus.rsp_mag), exp_mag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < N; i++) set_op(i, $urandom_range(255), $urandom_range(255));
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_rsp_valid", int'(bus.rsp_valid), 0);
    chk("rst_rsp_mag", int'(bus.rsp_mag), 0);
    chk("rst_rsp_id", int'(bus.rsp_id), 0);
    chk("rst_req_ready", int'(bus.req_ready), 0);
    bus.req_valid = '0;
    rst_n = 1'b1;
    tick();

    set_op(0, 3, 4);
    xact(4'b0001, 0, 0, gid);
    chk("first_id", gid, 0);

    set_op(2, 255, 255);
    xact(4'b0100, 0, 0, gid);
    set_op(1, 0, 0);
    xact(4'b0010, 5, 1, gid);
    set_op(3, 1, 1);
    xact(4'b1000, 0, 0, gid);

    for (int i = 0; i < N; i++) set_op(i, 10 + 37 * i, 200 - 41 * i);
    for (int g = 0; g < 5; g++) begin
      xact(4'b1111, 0, 1, gid);
      chk("rr_seq", gid, g % N);
    end

    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < N; i++) set_op(i, $urandom_range(255), $urandom_range(255));
      xact(4'($urandom_range(1, 15)), $urandom_range(0, 3), 1'($urandom_range(0, 1)), gid);
    end

    set_op(3, 30, 40);
    xact(4'b1000, 0, 0, gid);
    set_op(0, 200, 100);
    set_op(1, 7, 24);
    bus.req_valid = 4'b0001;
    #1;
    chk("abort_grant", int'(bus.req_ready), 1);
    tick();
    model_ptr = 0;
    bus.req_valid = 4'b0011;
    repeat (5) tick();
    chk("abort_busy_before", int'(busy), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_rsp_valid", int'(bus.rsp_valid), 0);
    chk("abort_rsp_mag", int'(bus.rsp_mag), 0);
    chk("abort_rsp_id", int'(bus.rsp_id), 0);
    chk("abort_req_ready", int'(bus.req_ready), 0);
    tick();
    rst_n = 1'b1;
    model_ptr = N - 1;
    xact(4'b0011, 0, 0, gid);
    chk("reset_ptr_first", gid, 0);
    xact(4'b0011, 0, 0, gid);
    chk("reset_ptr_second", gid, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
